// File: rtl/adder_accumulator_stage.sv
// adder_accumulator_stage: valid/ready accumulator that drives an external carry-select adder
module adder_accumulator_stage #(
  parameter int N   = 32,
  parameter bit SAT = 1,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_sub,
  input  logic          in_clear,
  input  logic          in_last,
  output logic [N-1:0]  add_a,
  output logic [N-1:0]  add_b,
  output logic          add_cin,
  input  logic [N-1:0]  add_s,
  input  logic          add_cout,
  input  logic          add_of,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_cout,
  output logic          out_of,
  output logic [CW-1:0] out_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic [N-1:0] acc, nxt;
  logic [CW-1:0] count, count_base, count_nxt;
  logic of_sticky, of_nxt, accept;
  assign in_ready = state != HOLD;
  assign accept = in_valid & in_ready;
  assign add_a = in_clear ? '0 : acc;
  assign add_b = in_sub ? ~in_data : in_data;
  assign add_cin = in_sub;
  assign nxt = (SAT && add_of) ? (add_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : add_s;
  assign of_nxt = (~in_clear & of_sticky) | add_of;
  assign count_base = in_clear ? '0 : count;
  assign count_nxt = &count_base ? count_base : count_base + CW'(1);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: HOLD waits for the consumer, otherwise advance on accepted beats
  always_comb begin
    state_nxt = state;
    if (state == HOLD) state_nxt = out_ready ? IDLE : HOLD;
    else if (accept) state_nxt = in_last ? HOLD : ACCUM;
  end
  // accumulator, sticky overflow, beat count and the held result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      of_sticky <= 1'b0;
      count <= '0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_of <= 1'b0;
      out_count <= '0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        out_valid <= 1'b0;
        acc <= '0;
        of_sticky <= 1'b0;
        count <= '0;
      end
    end else if (accept) begin
      acc <= nxt;
      of_sticky <= of_nxt;
      count <= count_nxt;
      if (in_last) begin
        out_valid <= 1'b1;
        out_sum <= nxt;
        out_cout <= add_cout;
        out_of <= of_nxt;
        out_count <= count_nxt;
      end
    end
endmodule

// File: tb/tb_adder_accumulator_stage.sv
// tb_adder_accumulator_stage: three parameter variants driven in lockstep against a behavioural model
module tb_adder_accumulator_stage;
  logic clk = 0, rst_n = 1;
  logic in_valid = 0, in_sub = 0, in_clear = 0, in_last = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic [2:0][31:0] add_a, add_b, add_s, out_sum;
  logic [2:0][15:0] out_count;
  logic [2:0] add_cin, add_cout, add_of, out_valid, in_ready, out_cout, out_of;
  int checks = 0, errors = 0;
  bit run = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam bit SAT = (g == 1) ? 1'b0 : 1'b1;
    localparam int CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] cnt;
    assign out_count[g] = 16'(cnt);
    assign {add_cout[g], add_s[g]} = {1'b0, add_a[g]} + {1'b0, add_b[g]} + 33'(add_cin[g]);
    assign add_of[g] = (add_a[g][31] == add_b[g][31]) && (add_s[g][31] != add_a[g][31]);
    adder_accumulator_stage #(.N(32), .SAT(SAT), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_data(in_data), .in_sub(in_sub), .in_clear(in_clear), .in_last(in_last),
      .add_a(add_a[g]), .add_b(add_b[g]), .add_cin(add_cin[g]),
      .add_s(add_s[g]), .add_cout(add_cout[g]), .add_of(add_of[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_sum(out_sum[g]),
      .out_cout(out_cout[g]), .out_of(out_of[g]), .out_count(cnt)
    );
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // behavioural model: packet totals as exact integers, clamped or wrapped to 32 bits
  bit sat_p[3] = '{1, 0, 1};
  int cmax[3] = '{65535, 65535, 3};
  longint m_acc[3] = '{0, 0, 0};
  bit m_of[3], m_hold[3], m_valid[3], m_cout[3], m_ofo[3];
  int m_cnt[3] = '{0, 0, 0}, m_cnto[3] = '{0, 0, 0};
  logic [31:0] m_sum[3] = '{0, 0, 0};
  initial begin
    longint base, d, ex, res, bu, du;
    bit ovf, co;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int g = 0; g < 3; g++) begin
        if (!rst_n) begin
          m_acc[g] = 0; m_of[g] = 0; m_cnt[g] = 0; m_hold[g] = 0; m_valid[g] = 0;
          m_sum[g] = 0; m_cout[g] = 0; m_ofo[g] = 0; m_cnto[g] = 0;
        end else if (m_hold[g]) begin
          if (out_ready) begin
            m_hold[g] = 0; m_valid[g] = 0; m_acc[g] = 0; m_of[g] = 0; m_cnt[g] = 0;
          end
        end else if (in_valid) begin
          base = in_clear ? 0 : m_acc[g];
          d = longint'($signed(in_data));
          ex = in_sub ? base - d : base + d;
          ovf = ex > 64'sh7FFFFFFF || ex < -64'sh80000000;
          res = ex;
          if (ovf) res = sat_p[g] ? (ex > 0 ? 64'sh7FFFFFFF : -64'sh80000000) : longint'($signed(ex[31:0]));
          bu = base & 64'hFFFFFFFF;
          du = {32'b0, in_data};
          co = in_sub ? (bu >= du) : (bu + du > 64'hFFFFFFFF);
          m_acc[g] = res;
          m_of[g] = (in_clear ? 1'b0 : m_of[g]) | ovf;
          m_cnt[g] = in_clear ? 1 : (m_cnt[g] + 1 > cmax[g] ? cmax[g] : m_cnt[g] + 1);
          if (in_last) begin
            m_hold[g] = 1; m_valid[g] = 1; m_sum[g] = res[31:0]; m_cout[g] = co;
            m_ofo[g] = m_of[g]; m_cnto[g] = m_cnt[g];
          end
        end
      end
    end
  end
  // compare every variant against the model on every falling edge
  initial forever begin
    @(negedge clk);
    if (run)
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("g%0d out_valid", g), 64'(out_valid[g]), 64'(m_valid[g]));
        chk($sformatf("g%0d in_ready", g), 64'(in_ready[g]), 64'(!m_hold[g]));
        if (m_valid[g]) begin
          chk($sformatf("g%0d out_sum", g), 64'(out_sum[g]), 64'(m_sum[g]));
          chk($sformatf("g%0d out_cout", g), 64'(out_cout[g]), 64'(m_cout[g]));
          chk($sformatf("g%0d out_of", g), 64'(out_of[g]), 64'(m_ofo[g]));
          chk($sformatf("g%0d out_count", g), 64'(out_count[g]), 64'(m_cnto[g]));
        end
      end
  end
  task automatic beat(input logic [31:0] dv, input bit s, input bit c, input bit l);
    in_valid = 1; in_data = dv; in_sub = s; in_clear = c; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_sub = 0; in_clear = 0; in_last = 0;
  endtask
  task automatic handshake();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  task automatic res_chk(input string nm, input int g, input logic [31:0] s, input bit co, input bit o, input int c);
    chk({nm, " valid"}, 64'(out_valid[g]), 64'd1);
    chk({nm, " sum"}, 64'(out_sum[g]), 64'(s));
    chk({nm, " cout"}, 64'(out_cout[g]), 64'(co));
    chk({nm, " of"}, 64'(out_of[g]), 64'(o));
    chk({nm, " count"}, 64'(out_count[g]), 64'(c));
  endtask
  initial begin
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_sum0", 64'(out_sum[0]), 64'd0);
    chk("reset out_count", 64'(out_count), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'h7);
    rst_n = 1;
    run = 1;
    beat(1, 0, 1, 0); beat(2, 0, 0, 0); beat(3, 0, 0, 0);
    rst_n = 0;
    #1;
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset in_ready", 64'(in_ready), 64'h7);
    chk("midreset out_cout", 64'(out_cout | out_of), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    beat(5, 0, 0, 0); beat(6, 0, 0, 1);
    res_chk("pkt5_6", 0, 11, 0, 0, 2);
    handshake();
    beat(10, 0, 1, 0); beat(20, 0, 0, 0); beat(5, 1, 0, 1);
    res_chk("pkt25", 0, 25, 1, 0, 3);
    res_chk("pkt25 cw2", 2, 25, 1, 0, 3);
    handshake();
    beat(32'h7FFFFFF0, 0, 1, 0); beat(32'h20, 0, 0, 1);
    res_chk("sat_pos", 0, 32'h7FFFFFFF, 0, 1, 2);
    res_chk("wrap_pos", 1, 32'h80000010, 0, 1, 2);
    handshake();
    beat(32'h80000000, 1, 0, 1);
    res_chk("sat_sub", 0, 32'h7FFFFFFF, 0, 1, 1);
    res_chk("wrap_sub", 1, 32'h80000000, 0, 1, 1);
    handshake();
    beat(1, 0, 1, 1);
    res_chk("after_of", 0, 1, 0, 0, 1);
    handshake();
    beat(7, 0, 1, 1);
    in_valid = 1; in_data = 99;
    repeat (4) begin
      res_chk("hold", 0, 7, 0, 0, 1);
      chk("hold in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    chk("handshake in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    chk("bubble out_valid", 64'(out_valid), 64'd0);
    chk("bubble in_ready", 64'(in_ready), 64'h7);
    beat(1, 0, 1, 0); beat(1, 0, 0, 0); beat(1, 0, 0, 0); beat(1, 0, 0, 0); beat(1, 0, 0, 1);
    res_chk("cnt_sat cw2", 2, 5, 0, 0, 3);
    res_chk("cnt cw16", 0, 5, 0, 0, 5);
    handshake();
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(399) != 0;
      in_valid = $urandom_range(3) != 0;
      in_sub = $urandom_range(1);
      in_clear = $urandom_range(3) == 0;
      in_last = $urandom_range(3) == 0;
      out_ready = $urandom_range(1);
      case ($urandom_range(3))
        0: in_data = $urandom;
        1: in_data = 32'h7FFFFF00 + $urandom_range(255);
        2: in_data = 32'h80000000 + $urandom_range(255);
        default: in_data = $urandom_range(15);
      endcase
      @(posedge clk); #1;
    end
    rst_n = 1; in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_accumulator_stage.md
Name: adder_accumulator_stage

Overview:
- Sequential stage that drives the combinational carry-select adder and consumes its outputs.
- Accepts a stream of signed operands under valid/ready and feeds {accumulator, operand} to the adder each accepted beat.
- Registers the adder result back into the accumulator, with optional signed saturation, sticky overflow and beat counting.
- Presents the packet total on a valid/ready output when the last beat arrives.

Parameters:
- N, 32, data width; must match the adder's N and be a multiple of 8.
- SAT, 1, 1 = clamp accumulator on signed overflow; 0 = wrap (two's complement).
- CW, 16, beat-counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  N  signed operand.
- in_sub  in  1  1 = subtract in_data from the accumulator.
- in_clear  in  1  1 = treat the accumulator as 0 for this beat (start of packet).
- in_last  in  1  final beat of the packet.
- add_a  out  N  adder operand A.
- add_b  out  N  adder operand B.
- add_cin  out  1  adder carry-in.
- add_s  in  N  adder sum.
- add_cout  in  1  adder carry-out.
- add_of  in  1  adder signed overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  N  packet total.
- out_cout  out  1  carry-out of the last beat.
- out_of  out  1  sticky: any beat of the packet overflowed.
- out_count  out  CW  beats in the packet, saturating at 2^CW-1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, of_sticky=0, count=0, out_valid=0, out_sum=0, out_cout=0, out_of=0, out_count=0. Reset asserted mid-packet or mid-HOLD discards everything; no output is produced.
- Adder drive (combinational, every cycle):
  - add_a = in_clear ? 0 : acc
  - add_b = in_sub ? ~in_data : in_data
  - add_cin = in_sub
- Accept = in_valid & in_ready. in_ready = (state != HOLD); it does not depend on in_valid.
- States:
  - IDLE: no packet in progress.
  - ACCUM: at least one beat accepted, no in_last yet.
  - HOLD: result presented, waiting for out_ready.
- Transitions:
  - IDLE/ACCUM, accept & !in_last -> ACCUM.
  - IDLE/ACCUM, accept & in_last -> HOLD.
  - HOLD, out_ready -> IDLE.
- On each accepted beat:
  - nxt = add_s. If SAT=1 and add_of=1: nxt = add_a[N-1] ? 100..0 : 011..1.
  - acc <= nxt.
  - of_sticky <= (in_clear ? 0 : of_sticky) | add_of.
  - count <= (in_clear ? 0 : count) + 1, saturating at the maximum.
- On accepting the in_last beat, the next cycle shows:
  - out_valid=1
  - out_sum=nxt, out_cout=add_cout
  - out_of = updated sticky, out_count = updated count
- Latency is 1 cycle from the last-beat accept to out_valid.
- HOLD:
  - Outputs stay stable while out_valid=1 & out_ready=0.
  - When out_ready=1: out_valid=0 next cycle, and acc, of_sticky and count clear to 0.
  - in_ready=0 throughout HOLD, including the cycle out_ready rises. This gives exactly one bubble cycle; there is no bypass.
- in_clear & in_last on the same beat is a one-beat packet: result = ±in_data, saturated if needed.
- A first beat in IDLE without in_clear uses acc, which is 0 after reset or after a HOLD handshake.
- Subtract overflow uses the adder's OF on (a, ~b, s), which is correct for a−b. In particular, 0 − (−2^(N-1)) overflows and saturates to +max.
- out_cout is the raw adder carry and is not adjusted by saturation.

Test Plan:
- Reset mid-ACCUM after 3 beats: rst_n=0 for 1 cycle -> all outputs 0, state IDLE, no out_valid. A following packet 5,6(last) -> out_sum=11, out_count=2.
- Packet {clear,10},{20},{sub,5}(last) -> one cycle later: out_sum=25, out_cout=1 (from the subtract), out_of=0, out_count=3.
- SAT=1, N=32: 0x7FFFFFF0 + 0x20 (last) -> out_sum=0x7FFFFFFF, out_of=1. With SAT=0: out_sum=0x80000010, out_of=1.
- SAT=1: subtract 0x80000000 from 0 -> out_sum=0x7FFFFFFF, out_of=1. Then the next packet {clear,1}(last) -> out_of=0, out_sum=1.
- Backpressure: hold out_ready=0 for 4 cycles -> out_* stable, in_ready=0, in_valid beats not accepted. On out_ready=1, in_ready rises the cycle after the handshake (one bubble).
- Counter saturation with CW=2: 5-beat packet of 1s -> out_count=3, out_sum=5.
